// File: rtl/mux_8_1_sched.sv
// mux_8_1_sched: round-robin burst-limited scheduler for the 8:1 channel; MUX_SCHED_LOCK_EN adds the lock burst-extend input
module mux_8_1_sched #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] i,
`ifdef MUX_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       f,
    output logic       f_vld
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [3:0] LAST = 4'(BURST - 1);
    if (BURST < 1 || BURST > 16) begin : g_bad_burst
        $error("BURST must be within 1..16");
    end
    state_t     st, st_n;
    logic [2:0] ptr, own, win;
    logic [3:0] cnt;
    logic       hold, rel, cap;
`ifdef MUX_SCHED_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif
    always_comb begin
        win = ptr;
        for (int k = 7; k >= 0; k--) if (req[ptr + 3'(k)]) win = ptr + 3'(k);
    end
    assign rel = !req[own] || (cnt == LAST && !hold);
    assign cap = st == GRANT && req[own];
    always_comb begin
        st_n = st;
        st_n = (st == IDLE) ? (|req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= st_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= 3'd0;
            own   <= 3'd0;
            cnt   <= 4'd0;
            f     <= 1'b0;
            f_vld <= 1'b0;
        end else begin
            f_vld <= cap;
            if (cap) f <= i[own];
            if (st == IDLE && |req) begin
                own <= win;
                cnt <= 4'd0;
            end else if (st == GRANT && rel) ptr <= own + 3'd1;
            else if (st == GRANT && cnt != LAST) cnt <= cnt + 4'd1;
        end
    end
    assign sel  = own;
    assign busy = st == GRANT;
    assign gnt  = busy ? 8'd1 << own : 8'd0;
endmodule

// File: tb/tb_mux_8_1_sched.sv
// tb_mux_8_1_sched: randomized and directed checks of mux_8_1_sched against a cycle-level behavioural model
module tb_mux_8_1_sched;
    localparam int BURST = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] i = 8'd0;
    logic       lock = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy, f, f_vld;
    int         total = 0;
    int         passed = 0;
    int         m_busy, m_own, m_ptr, m_used, m_f, m_fv;

    mux_8_1_sched #(.BURST(BURST)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .i(i),
`ifdef MUX_SCHED_LOCK_EN
        .lock(lock),
`endif
        .sel(sel),
        .gnt(gnt),
        .busy(busy),
        .f(f),
        .f_vld(f_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_ptr = 0; m_used = 0; m_f = 0; m_fv = 0;
    endtask

    task automatic model_edge();
        int lk;
`ifdef MUX_SCHED_LOCK_EN
        lk = lock;
`else
        lk = 0;
`endif
        if (!m_busy) begin
            m_fv = 0;
            if (req != 0) begin
                for (int k = 7; k >= 0; k--) if (req[(m_ptr + k) % 8]) m_own = (m_ptr + k) % 8;
                m_busy = 1;
                m_used = 1;
            end
        end else begin
            m_fv = req[m_own];
            if (req[m_own]) m_f = i[m_own];
            if (!req[m_own] || (m_used >= BURST && !lk)) begin
                m_busy = 0;
                m_ptr = (m_own + 1) % 8;
            end else m_used++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), m_busy ? 32'(1) << m_own : 32'd0);
        chk({tag, ".sel"}, 32'(sel), 32'(m_own));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".f"}, 32'(f), 32'(m_f));
        chk({tag, ".f_vld"}, 32'(f_vld), 32'(m_fv));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_edge();
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        #1 check_all("rst_async");
        repeat (2) step("rst_hold");
        rst = 1'b0;
        repeat (10) step("idle");
        req = 8'h04;
        repeat (15) step("single");
        req = 8'h00;
        repeat (2) step("single_off");
        req = 8'hFF;
        repeat (45) step("rr");
        req = 8'h00;
        repeat (2) step("rr_off");
        rst = 1'b1; model_reset();
        step("rst2");
        rst = 1'b0;
        req = 8'h10;
        repeat (6) step("to_ptr5");
        req = 8'h21;
        step("early_arb");
        step("early_g1");
        req = 8'h01;
        step("early_drop");
        step("early_next");
        repeat (3) step("early_tail");
        req = 8'h00;
        repeat (3) step("early_off");
        req = 8'h08;
        i = 8'h00;
        step("dp_arb");
        i = 8'h08; step("dp_1");
        i = 8'h00; step("dp_0");
        i = 8'h08; step("dp_1b");
        #3 rst = 1'b1;
        model_reset();
        #1 check_all("rst_mid");
        step("rst_mid_hold");
        #2 rst = 1'b0;
        req = 8'h02;
        lock = 1'b1;
        repeat (10) step("lock_on");
        lock = 1'b0;
        repeat (6) step("lock_off");
        req = 8'h00;
        repeat (2) step("lock_idle");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            i = 8'($urandom);
            lock = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 150) == 0) begin
                rst = 1'b1;
                model_reset();
                step("rand_rst");
                rst = 1'b0;
            end else step("rand");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
